// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a payload word over valid/ready and sends it
// as sync 1,0,1 + payload MSB first + GAP_BITS zeros, then counts the frame.
module seq_frame_tx #(
    parameter int DATA_W   = 8,
    parameter int BIT_DIV  = 1,
    parameter int GAP_BITS = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int MAX_LEN = (DATA_W > GAP_BITS) ? ((DATA_W > 3) ? DATA_W : 3)
                                                 : ((GAP_BITS > 3) ? GAP_BITS : 3);
    localparam int BIT_W   = $clog2(MAX_LEN);
    localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [BIT_W-1:0]  bit_idx, bit_idx_next;
    logic [DIV_W-1:0]  div_cnt, div_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next, shifted;
    logic              data_out_next;
    logic              frame_done_next;
    logic              div_tc;
    logic              last_sync, last_data, last_gap;

    assign div_tc    = (div_cnt == DIV_W'(BIT_DIV - 1));
    assign last_sync = (bit_idx == BIT_W'(2));
    assign last_data = (bit_idx == BIT_W'(DATA_W - 1));
    assign last_gap  = (bit_idx == BIT_W'(GAP_BITS - 1));
    assign shifted   = shift_reg << 1;

    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the shift register is reset along with the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            div_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            bit_idx     <= bit_idx_next;
            div_cnt     <= div_cnt_next;
            shift_reg   <= shift_next;
            data_out    <= data_out_next;
            frame_done  <= frame_done_next;
            frame_count <= frame_count + CNT_W'(frame_done_next);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tx_valid)              state_next = SYNC;
            SYNC: if (div_tc && last_sync)   state_next = DATA;
            DATA: if (div_tc && last_data)   state_next = GAP;
            GAP:  if (div_tc && last_gap)    state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Next values of the datapath registers; the bit index restarts whenever
    // the phase changes, and data_out is loaded with the bit about to be sent.
    always_comb begin
        // NOTE: every variable gets a default here so no latch is inferred.
        bit_idx_next    = bit_idx;
        div_cnt_next    = div_cnt;
        shift_next      = shift_reg;
        data_out_next   = data_out;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                bit_idx_next  = '0;
                div_cnt_next  = '0;
                data_out_next = 1'b0;
                if (tx_valid) begin
                    shift_next    = tx_data;
                    data_out_next = 1'b1;
                end
            end
            SYNC, DATA, GAP: begin
                if (!div_tc) begin
                    div_cnt_next = div_cnt + 1'b1;
                end else begin
                    div_cnt_next = '0;
                    bit_idx_next = (state_next != state) ? '0 : bit_idx + 1'b1;
                    case (state)
                        SYNC: data_out_next = last_sync ? shift_reg[DATA_W-1]
                                                        : (bit_idx == BIT_W'(1));
                        DATA: begin
                            if (last_data) begin
                                data_out_next = 1'b0;
                            end else begin
                                shift_next    = shifted;
                                data_out_next = shifted[DATA_W-1];
                            end
                        end
                        default: begin
                            data_out_next   = 1'b0;
                            frame_done_next = last_gap;
                        end
                    endcase
                end
            end
            default: begin
                bit_idx_next  = '0;
                div_cnt_next  = '0;
                data_out_next = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter feeding the Mealy "101" sequence detector path.
- Accepts a parallel payload word over a valid/ready handshake.
- Serialises it as one frame on a single-bit line: sync pattern 1,0,1, then the payload MSB first, then a run of 0 gap bits.
- Line idles at 0. Serves as the stimulus/transmit end for the detector and counts frames sent.

Parameters:
- DATA_W, 8: payload width in bits; must be >= 1.
- BIT_DIV, 1: clock cycles each serial bit is held on data_out; must be >= 1.
- GAP_BITS, 2: number of 0 bits appended after the payload; must be >= 1.
- CNT_W, 8: width of frame_count.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  payload word; sampled only on handshake.
- tx_valid  input  1  producer has a payload word available.
- tx_ready  output  1  block can accept a word (IDLE only).
- data_out  output  1  serial line, registered.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  single-cycle pulse when a frame completes.
- frame_count  output  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising clk edge; it has priority over all other logic.
- Reset values: state=IDLE, data_out=0, busy=0, tx_ready=1, frame_done=0, frame_count=0, bit and divider counters=0. tx_valid is ignored while reset is high.
- Handshake: a word is accepted at the rising edge where tx_ready=1 and tx_valid=1. tx_data is latched into the shift register at that edge. Later changes to tx_data have no effect on the current frame.
- Frame length: F = 3 + DATA_W + GAP_BITS bits. Bit order: 1, 0, 1, tx_data[DATA_W-1] ... tx_data[0], then GAP_BITS zeros.
- Timing: let E0 be the accept edge. Bit k (0 <= k < F) is on data_out during cycles E0+k*BIT_DIV+1 through E0+(k+1)*BIT_DIV.
- Handshake output timing: tx_ready drops to 0 and busy rises to 1 from the cycle after E0.
- Frame end (edge E0+F*BIT_DIV):
  - state returns to IDLE; data_out=0, busy=0, tx_ready=1;
  - frame_done=1 for exactly that one cycle;
  - frame_count increments by 1, and 2^CNT_W-1 wraps to 0.
- Back-to-back: the earliest next accept is edge E0+F*BIT_DIV+1. Frame period is therefore F*BIT_DIV+1 cycles, with exactly one idle 0 cycle between frames.
- State machine:
  - IDLE: data_out=0. On accept, go to SYNC with bit index 0.
  - SYNC: emit 1,0,1; after 3 bit periods, go to DATA.
  - DATA: shift out DATA_W bits MSB first; after DATA_W bit periods, go to GAP.
  - GAP: emit 0 for GAP_BITS bit periods, then go to IDLE.
  - Any illegal state encoding goes to IDLE with data_out=0.
- Divider: a counter runs 0..BIT_DIV-1 and advances the bit index on terminal count. With BIT_DIV=1 the bit index advances every cycle.
- Reset mid-frame: the frame is abandoned at that edge and all reset values apply on the next cycle. frame_done does not pulse and frame_count is not incremented for the abandoned frame.
- tx_valid deasserted in IDLE: the block stays in IDLE indefinitely with data_out=0.
- Payload content: no stuffing is applied. A payload containing 101 is sent verbatim.

Test Plan:
- Single frame: DATA_W=8, BIT_DIV=1, GAP_BITS=2, tx_data=8'hA5, one-cycle tx_valid.
  - data_out over cycles E0+1..E0+13 = 1,0,1,1,0,1,0,0,1,0,1,0,0.
  - busy=1 over that window; tx_ready=0 over that window.
  - At E0+13: frame_done=1 for one cycle, frame_count=1, tx_ready=1.
- Divider: BIT_DIV=4, tx_data=8'hFF.
  - Each bit is held exactly 4 cycles; the frame spans 52 cycles.
  - data_out=1 for E0+1..4, 0 for 5..8, then 1 for 9..44, then 0 after that.
- Back-to-back: tx_valid held high with tx_data=8'h3C then 8'hC3 (BIT_DIV=1).
  - Accept edges are exactly 14 cycles apart, with one idle 0 cycle between frames.
  - frame_count steps 1 then 2; second frame payload bits are 1,1,0,0,0,0,1,1.
- Data hold: change tx_data from 8'h00 to 8'hFF one cycle after accept (BIT_DIV=1).
  - Payload bits (cycles E0+4..E0+11) are all 0.
- Reset mid-frame: assert reset for 1 cycle at E0+6.
  - Next cycle: data_out=0, busy=0, tx_ready=1, frame_count=0, and no frame_done pulse.
  - A new accept afterwards produces a complete, correct frame.
- Wrap: CNT_W=2, five consecutive frames.
  - frame_count sequence is 1,2,3,0,1; frame_done pulses exactly 5 times.
